lcd_slot_arbiter: RTL and testbench
===================================

Name: lcd_slot_arbiter

Overview:
- Owns the twelve 8-bit character slots (d0x0..d0x5 on line 0, d1x0..d1x5 on line 1) that feed the LCD driver.
- Lets N_REQ independent producers (counters, decoders, challenge blocks) share that slot file through a round-robin, request/acknowledge write port.
- Sits between the producer blocks and the LCD driver in the board top level; one instance per design.

Parameters:
- N_REQ, 4, number of requester ports (2..8).
- BLANK_CHAR, 8'h20, value loaded into every slot at reset and on clear (ASCII space).

Ports:
- iCLK  in  1  system clock (CLOCK_50 domain).
- iRST_N  in  1  asynchronous active-low reset.
- iCLR  in  1  synchronous clear of all slots to BLANK_CHAR.
- iREQ  in  N_REQ  per-requester write request, level.
- iADDR  in  4*N_REQ  slot address per requester; requester i uses bits [4i+3:4i]. 0..5 = d0x0..d0x5, 6..11 = d1x0..d1x5.
- iDATA  in  8*N_REQ  write data per requester; requester i uses bits [8i+7:8i].
- oACK  out  N_REQ  one-hot, one-cycle acknowledge.
- oERR  out  1  one-cycle pulse: the acknowledged write had an address of 12..15.
- oWR_CNT  out  8  count of completed valid writes, wraps 255->0.
- d0x0..d0x5, d1x0..d1x5  out  8 each  registered slot contents.

Behaviour:
- Reset (async, iRST_N=0):
  - all slots = BLANK_CHAR; oACK = 0; oERR = 0; oWR_CNT = 0.
  - RR pointer last = N_REQ-1, so requester 0 has highest priority first.
- Eligibility: eligible = iREQ & ~oACK. A requester being acknowledged this cycle cannot be re-granted this cycle.
- Arbitration, every rising edge with iCLR=0 and eligible != 0:
  - Winner w is the first eligible index searching last+1, last+2, ... modulo N_REQ.
  - Exactly one grant per cycle.
  - Same edge: if iADDR[w] <= 11, slot[iADDR[w]] <= iDATA[w] and oWR_CNT increments.
  - Same edge: last <= w; oACK <= one-hot(w).
  - Next cycle: oACK[w] = 1 for exactly one cycle.
- Latency: request sampled at edge k -> slot updated and oACK visible after edge k. Max throughput is one write per cycle across all requesters. A single requester gets at most one write every 2 cycles.
- Requester protocol:
  - Hold iREQ, iADDR and iDATA stable until oACK[i] is seen.
  - Deassert, or present a new request, in the ack cycle. A held request in the ack cycle is masked; it is eligible again next cycle.
  - Dropping iREQ before ack: no write, no ack, no error.
- Invalid address (12..15): no slot written, oWR_CNT unchanged. oACK given normally, and oERR = 1 in the same cycle as oACK.
- No eligible request: oACK = 0, oERR = 0, slots hold, pointer holds.
- iCLR = 1 at an edge:
  - all slots <= BLANK_CHAR; oACK <= 0; oERR <= 0; no grant; pointer and oWR_CNT hold.
  - Pending requests stay pending and are arbitrated after iCLR falls.
- Reset asserted mid-transaction: async clear of everything, including a pending oACK. Requesters must restart.
- Slot outputs change only at a clock edge (or async reset) and never glitch combinationally.
- Width rule: address compare is unsigned 4-bit; oWR_CNT is modulo-256.

Test Plan:
- Reset -> all 12 slots = 8'h20, oACK = 0, oWR_CNT = 0. Assert iRST_N low mid-write -> outputs return to reset values asynchronously, before the next edge.
- Single write: req0 with addr 3, data 8'h41 -> after 1 edge, d0x3 = 8'h41, oACK = 4'b0001 for 1 cycle, oWR_CNT = 1. req0 held through the ack cycle -> no second grant in that cycle.
- Contention from reset: req0..3 all held continuously, each re-requesting right after its ack. Addrs 0,6,11,5; data 'A','B','C','D' -> grants in order 0,1,2,3, one per cycle. Final d0x0 = 'A', d1x0 = 'B', d1x5 = 'C', d0x5 = 'D'; oWR_CNT = 4.
- Fairness: req0 and req2 asserted permanently -> acks alternate 0,2,0,2. Neither requester is granted twice in a row.
- Invalid address: req1 with addr 13, data 8'hFF -> oACK = 4'b0010 and oERR = 1 in the same cycle. All slots unchanged; oWR_CNT unchanged.
- Clear vs write: iCLR = 1 on the same edge as req3 (addr 2, data 8'h5A) -> all slots = 8'h20, no ack. iCLR drops -> next edge writes d0x2 = 8'h5A and acks requester 3.
- Wrap: 256 valid writes -> oWR_CNT = 0.

Source files
------------

// File: rtl/lcd_slot_arbiter.sv
// Twelve-character LCD slot file shared by N_REQ producers through a
// round-robin request/acknowledge write port with invalid-address flagging.
module lcd_slot_arbiter #(
    parameter int          N_REQ      = 4,
    parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic                 iCLR,
    input  logic [N_REQ-1:0]     iREQ,
    input  logic [4*N_REQ-1:0]   iADDR,
    input  logic [8*N_REQ-1:0]   iDATA,
    output logic [N_REQ-1:0]     oACK,
    output logic                 oERR,
    output logic [7:0]           oWR_CNT,
    output logic [7:0]           d0x0,
    output logic [7:0]           d0x1,
    output logic [7:0]           d0x2,
    output logic [7:0]           d0x3,
    output logic [7:0]           d0x4,
    output logic [7:0]           d0x5,
    output logic [7:0]           d1x0,
    output logic [7:0]           d1x1,
    output logic [7:0]           d1x2,
    output logic [7:0]           d1x3,
    output logic [7:0]           d1x4,
    output logic [7:0]           d1x5
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int N_SLOTS = 12;

    logic [7:0]       r_slot [N_SLOTS];
    logic [N_REQ-1:0] r_ack;
    logic             r_err;
    logic [7:0]       r_wr_cnt;
    logic [IDX_W-1:0] r_last;

    logic [N_REQ-1:0] w_elig;
    logic             w_found;
    logic [IDX_W-1:0] w_win;
    logic [3:0]       w_addr;
    logic [7:0]       w_data;
    logic [3:0]       w_addr_arr [N_REQ];
    logic [7:0]       w_data_arr [N_REQ];
    int               v_idx;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_addr_arr[gi] = iADDR[4*gi+3:4*gi];
            assign w_data_arr[gi] = iDATA[8*gi+7:8*gi];
        end
    endgenerate

    // A requester whose ack is showing this cycle is masked so it cannot be
    // granted twice on the same held request.
    assign w_elig = iREQ & ~r_ack;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        v_idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            v_idx = (int'(r_last) + k) % N_REQ;
            if (!w_found && w_elig[v_idx]) begin
                w_found = 1'b1;
                w_win   = IDX_W'(v_idx);
            end
        end
    end

    assign w_addr = w_addr_arr[w_win];
    assign w_data = w_data_arr[w_win];

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int s = 0; s < N_SLOTS; s++) begin
                r_slot[s] <= BLANK_CHAR;
            end
            r_ack    <= '0;
            r_err    <= 1'b0;
            r_wr_cnt <= 8'd0;
            r_last   <= IDX_W'(N_REQ - 1);
        end else if (iCLR) begin
            // Clear blanks the display but keeps pointer and write count.
            for (int s = 0; s < N_SLOTS; s++) begin
                r_slot[s] <= BLANK_CHAR;
            end
            r_ack <= '0;
            r_err <= 1'b0;
        end else begin
            r_ack <= '0;
            r_err <= 1'b0;
            if (w_found) begin
                r_ack  <= N_REQ'(1) << w_win;
                r_last <= w_win;
                if (w_addr <= 4'd11) begin
                    r_slot[w_addr] <= w_data;
                    r_wr_cnt       <= r_wr_cnt + 8'd1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign oACK    = r_ack;
    assign oERR    = r_err;
    assign oWR_CNT = r_wr_cnt;

    assign d0x0 = r_slot[0];
    assign d0x1 = r_slot[1];
    assign d0x2 = r_slot[2];
    assign d0x3 = r_slot[3];
    assign d0x4 = r_slot[4];
    assign d0x5 = r_slot[5];
    assign d1x0 = r_slot[6];
    assign d1x1 = r_slot[7];
    assign d1x2 = r_slot[8];
    assign d1x3 = r_slot[9];
    assign d1x4 = r_slot[10];
    assign d1x5 = r_slot[11];

endmodule

// File: tb/tb_lcd_slot_arbiter.sv
// Directed and randomized bench for lcd_slot_arbiter against a cycle-level
// behavioural model of the slot file and round-robin grant rule.
module tb_lcd_slot_arbiter;

    localparam int NR = 4;

    logic            iCLK = 1'b0;
    logic            iRST_N = 1'b0;
    logic            iCLR = 1'b0;
    logic [NR-1:0]   iREQ = '0;
    logic [4*NR-1:0] iADDR = '0;
    logic [8*NR-1:0] iDATA = '0;
    logic [NR-1:0]   oACK;
    logic            oERR;
    logic [7:0]      oWR_CNT;
    logic [7:0]      d0x0, d0x1, d0x2, d0x3, d0x4, d0x5;
    logic [7:0]      d1x0, d1x1, d1x2, d1x3, d1x4, d1x5;

    lcd_slot_arbiter #(.N_REQ(NR), .BLANK_CHAR(8'h20)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iCLR(iCLR), .iREQ(iREQ),
        .iADDR(iADDR), .iDATA(iDATA), .oACK(oACK), .oERR(oERR),
        .oWR_CNT(oWR_CNT),
        .d0x0(d0x0), .d0x1(d0x1), .d0x2(d0x2), .d0x3(d0x3), .d0x4(d0x4), .d0x5(d0x5),
        .d1x0(d1x0), .d1x1(d1x1), .d1x2(d1x2), .d1x3(d1x3), .d1x4(d1x4), .d1x5(d1x5)
    );

    always #5 iCLK = ~iCLK;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]    m_slot [12];
    int            m_last;
    logic [NR-1:0] m_ack;
    logic          m_err;
    logic [7:0]    m_cnt;

    function automatic logic [95:0] dut_slots();
        return {d1x5, d1x4, d1x3, d1x2, d1x1, d1x0, d0x5, d0x4, d0x3, d0x2, d0x1, d0x0};
    endfunction

    function automatic logic [95:0] model_slots();
        logic [95:0] v;
        for (int s = 0; s < 12; s++) v[8*s +: 8] = m_slot[s];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 12; s++) m_slot[s] = 8'h20;
        m_last = NR - 1;
        m_ack  = '0;
        m_err  = 1'b0;
        m_cnt  = 8'd0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_ack"}, 128'(oACK), 128'(m_ack));
        chk({tag, "_err"}, 128'(oERR), 128'(m_err));
        chk({tag, "_cnt"}, 128'(oWR_CNT), 128'(m_cnt));
        chk({tag, "_slots"}, 128'(dut_slots()), 128'(model_slots()));
    endtask

    // One clock: model computes the result of the coming edge from the
    // present inputs, then DUT is sampled 1 time unit after the edge.
    task automatic step(input string tag);
        logic [NR-1:0] elig;
        int            w;
        logic [3:0]    a;
        elig = iREQ & ~m_ack;
        w = -1;
        for (int k = 1; k <= NR; k++) begin
            if (w < 0 && elig[(m_last + k) % NR]) w = (m_last + k) % NR;
        end
        m_ack = '0;
        m_err = 1'b0;
        if (iCLR) begin
            for (int s = 0; s < 12; s++) m_slot[s] = 8'h20;
        end else if (w >= 0) begin
            m_ack  = NR'(1) << w;
            m_last = w;
            a = iADDR[4*w +: 4];
            if (a < 4'd12) begin
                m_slot[a] = iDATA[8*w +: 8];
                m_cnt = m_cnt + 8'd1;
            end else begin
                m_err = 1'b1;
            end
        end
        @(posedge iCLK);
        #1;
        check_all(tag);
        $display("step %s: req=%b ack=%b err=%b cnt=%0d", tag, iREQ, oACK, oERR, oWR_CNT);
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [7:0] d);
        iREQ[i] = 1'b1;
        iADDR[4*i +: 4] = a;
        iDATA[8*i +: 8] = d;
    endtask

    task automatic do_reset();
        iRST_N = 1'b0;
        iREQ = '0;
        iCLR = 1'b0;
        model_reset();
        @(negedge iCLK);
        iRST_N = 1'b1;
        @(posedge iCLK);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge iCLK);
        #1;
        check_all("reset");
        do_reset();
        check_all("reset_rel");

        // Single write, then the same request held through the ack cycle
        set_req(0, 4'd3, 8'h41);
        step("single");
        chk("single_d0x3", 128'(d0x3), 128'(8'h41));
        chk("single_ack", 128'(oACK), 128'(4'b0001));
        chk("single_cnt", 128'(oWR_CNT), 128'(8'd1));
        step("held_masked");
        chk("held_masked_ack", 128'(oACK), 128'(4'b0000));
        iREQ = '0;
        step("idle");

        // Async reset while an ack is showing
        set_req(1, 4'd7, 8'h55);
        step("pre_rst");
        chk("pre_rst_ack", 128'(oACK), 128'(4'b0010));
        iRST_N = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        iREQ = '0;
        @(negedge iCLK);
        iRST_N = 1'b1;

        // Contention from reset: all four held continuously
        set_req(0, 4'd0, "A");
        set_req(1, 4'd6, "B");
        set_req(2, 4'd11, "C");
        set_req(3, 4'd5, "D");
        for (int k = 0; k < 4; k++) begin
            step("contend");
            chk("contend_order", 128'(oACK), 128'(NR'(1) << k));
        end
        chk("contend_d0x0", 128'(d0x0), 128'(8'h41));
        chk("contend_d1x0", 128'(d1x0), 128'(8'h42));
        chk("contend_d1x5", 128'(d1x5), 128'(8'h43));
        chk("contend_d0x5", 128'(d0x5), 128'(8'h44));
        chk("contend_cnt", 128'(oWR_CNT), 128'(8'd4));
        iREQ = '0;
        step("idle");

        // Fairness between requesters 0 and 2
        set_req(0, 4'd1, 8'h30);
        set_req(2, 4'd2, 8'h31);
        for (int k = 0; k < 6; k++) begin
            step("fair");
            chk("fair_alt", 128'(oACK), 128'((k % 2 == 0) ? 4'b0001 : 4'b0100));
        end
        iREQ = '0;
        step("idle");

        // Invalid address
        set_req(1, 4'd13, 8'hFF);
        step("invalid");
        chk("invalid_ack", 128'(oACK), 128'(4'b0010));
        chk("invalid_err", 128'(oERR), 128'(1'b1));
        iREQ = '0;
        step("idle");

        // Clear coinciding with a request
        set_req(3, 4'd2, 8'h5A);
        iCLR = 1'b1;
        step("clear");
        chk("clear_slots", 128'(dut_slots()), 128'({12{8'h20}}));
        chk("clear_ack", 128'(oACK), 128'(4'b0000));
        iCLR = 1'b0;
        step("after_clr");
        chk("after_clr_d0x2", 128'(d0x2), 128'(8'h5A));
        chk("after_clr_ack", 128'(oACK), 128'(4'b1000));
        iREQ = '0;
        step("idle");

        // Counter wrap: 256 valid writes from reset
        do_reset();
        set_req(0, 4'd4, 8'h61);
        set_req(1, 4'd9, 8'h62);
        for (int k = 0; k < 256; k++) begin
            step("wrap");
            if (k == 254) chk("wrap_255", 128'(oWR_CNT), 128'(8'd255));
        end
        chk("wrap_zero", 128'(oWR_CNT), 128'(8'd0));
        iREQ = '0;
        step("idle");

        // Randomized requester agents obeying the hold-until-ack protocol
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (iREQ[i] && oACK[i]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(i, ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15))
                                                              : 4'($urandom_range(0, 11)), 8'($urandom));
                    else
                        iREQ[i] = 1'b0;
                end else if (iREQ[i]) begin
                    if ($urandom_range(0, 15) == 0) iREQ[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    set_req(i, ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15))
                                                          : 4'($urandom_range(0, 11)), 8'($urandom));
                end
            end
            iCLR = ($urandom_range(0, 31) == 0);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
